// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - 24-bit SPI mode-0 DAC frame driver; optional DAC_OFFSET_BIN_EN selects offset-binary data
module dac_spi_tx #(
  parameter int         SCLK_DIV = 2,
  parameter int         CS_HOLD  = 2,
  parameter logic [7:0] CMD      = 8'h30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [15:0] modulated,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        overrun
);

  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]       hold;
  logic              pending;
  logic [15:0]       data;
  logic [23:0]       frame;
  logic [22:0]       shreg;
  logic [DIV_W-1:0]  div;
  logic [4:0]        bit_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic start;
  logic div_wrap;
  logic last_fall;
  logic hold_done;

`ifdef DAC_OFFSET_BIN_EN
  // Flip the sign bit: two's complement to offset binary for unipolar DACs
  assign data = {~hold[15], hold[14:0]};
`else
  assign data = hold;
`endif

  assign frame     = {CMD, data};
  assign div_wrap  = (div == DIV_W'(SCLK_DIV - 1));
  assign last_fall = (state == S_SHIFT) && div_wrap && sclk && (bit_cnt == 5'd24);
  assign hold_done = (state == S_HOLD) && (hold_cnt == HOLD_W'(CS_HOLD - 1));
  assign busy      = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start marks the edge that launches a frame
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_nxt = S_SHIFT;
          start     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (last_fall) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Holding register; a strobe on the launch edge refills it without counting as an overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= 16'h0000;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (sample_en) begin
      hold    <= modulated;
      pending <= 1'b1;
      if (pending && !start) begin
        overrun <= 1'b1;
      end
    end else if (start) begin
      pending <= 1'b0;
    end
  end

  // Serialiser: divider, SPI clock, shift register and inter-frame hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      div      <= '0;
      bit_cnt  <= 5'd0;
      hold_cnt <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else if (start) begin
      shreg   <= frame[22:0];
      mosi    <= frame[23];
      cs_n    <= 1'b0;
      sclk    <= 1'b0;
      div     <= '0;
      bit_cnt <= 5'd0;
    end else if (state == S_SHIFT) begin
      if (div_wrap) begin
        div <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          bit_cnt <= bit_cnt + 5'd1;
        end else if (bit_cnt == 5'd24) begin
          sclk     <= 1'b0;
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          hold_cnt <= '0;
        end else begin
          sclk  <= 1'b0;
          mosi  <= shreg[22];
          shreg <= {shreg[21:0], 1'b0};
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end else if (state == S_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - randomized self-checking bench for dac_spi_tx against a frame-level model
module tb_dac_spi_tx;

  localparam int D  = 2;
  localparam int H  = 2;
  localparam int FD = 1;
  localparam int FH = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [15:0] modulated = 16'h0000;
  logic        sclk, cs_n, mosi, busy, overrun;
  logic        f_sample_en = 1'b0;
  logic [15:0] f_modulated = 16'h0000;
  logic        f_sclk, f_cs_n, f_mosi, f_busy, f_overrun;

  int vectors = 0;
  int miscompares = 0;

  dac_spi_tx #(.SCLK_DIV(D), .CS_HOLD(H), .CMD(8'h30)) u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .modulated(modulated),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .busy(busy), .overrun(overrun)
  );

  dac_spi_tx #(.SCLK_DIV(FD), .CS_HOLD(FH), .CMD(8'h30)) u_dut_fast (
    .clk(clk), .rst(rst), .sample_en(f_sample_en), .modulated(f_modulated),
    .sclk(f_sclk), .cs_n(f_cs_n), .mosi(f_mosi), .busy(f_busy), .overrun(f_overrun)
  );

  always #5 clk = ~clk;

  // Observed traffic, sampled 1 time unit after every rising clk edge
  int          cyc = 0;
  bit          in_frame = 1'b0;
  logic [23:0] sh = '0;
  int          nbits = 0;
  int          fall_t = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          fall_q[$];
  logic [23:0] frame_q[$];
  int          len_q[$];
  int          bits_q[$];
  logic        f_prev_cs = 1'b1, f_prev_sclk = 1'b0, f_prev_mosi = 1'b0;
  int          f_fall_t = 0;
  int          f_fall_q[$];
  int          f_len_q[$];
  int          f_viol = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      in_frame = 1'b0;
      nbits = 0;
    end else begin
      if (prev_cs && !cs_n) begin
        in_frame = 1'b1; fall_t = cyc; nbits = 0; sh = '0;
        fall_q.push_back(cyc);
      end
      if (in_frame && !cs_n && !prev_sclk && sclk) begin
        sh = {sh[22:0], mosi};
        nbits = nbits + 1;
      end
      if (in_frame && !prev_cs && cs_n) begin
        in_frame = 1'b0;
        frame_q.push_back(sh);
        len_q.push_back(cyc - fall_t);
        bits_q.push_back(nbits);
      end
      if (f_prev_cs && !f_cs_n) begin
        f_fall_t = cyc;
        f_fall_q.push_back(cyc);
      end
      if (!f_prev_cs && f_cs_n) f_len_q.push_back(cyc - f_fall_t);
      if (!f_prev_cs && !f_cs_n) begin
        if (f_sclk == f_prev_sclk) f_viol = f_viol + 1;
        if ((f_mosi != f_prev_mosi) && !(f_prev_sclk && !f_sclk)) f_viol = f_viol + 1;
      end
    end
    prev_cs = cs_n; prev_sclk = sclk;
    f_prev_cs = f_cs_n; f_prev_sclk = f_sclk; f_prev_mosi = f_mosi;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame the DAC should see for a captured sample (offset binary = add half scale)
  function automatic logic [23:0] exp_frame(input logic [15:0] v);
    logic [15:0] d;
`ifdef DAC_OFFSET_BIN_EN
    d = v + 16'h8000;
`else
    d = v;
`endif
    return {8'h30, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe(input logic [15:0] v, output int s);
    @(posedge clk);
    #2;
    sample_en = 1'b1;
    modulated = v;
    s = cyc + 1;
    @(posedge clk);
    #2;
    sample_en = 1'b0;
  endtask

  task automatic clear_mon();
    fall_q.delete(); frame_q.delete(); len_q.delete(); bits_q.delete();
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (frame_q.size() < n && k < limit) begin
      tick(1);
      k++;
    end
    vectors++;
    if (frame_q.size() < n) begin
      miscompares++;
      $display("FAIL frame_timeout: got %0d frames, need %0d", frame_q.size(), n);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    vectors++; if (mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    tick(3);
    vectors++; if (cs_n !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: cs_n=%b busy=%b want 1/0", cs_n, busy); end
  endtask

  task automatic test_single();
    logic [15:0] vals[4];
    logic [23:0] f;
    int s;
    vals[0] = 16'h0000; vals[1] = 16'h7FFF; vals[2] = 16'h8000; vals[3] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      strobe(vals[i], s);
      tick(1);
      f = exp_frame(vals[i]);
      vectors++; if (cs_n !== 1'b0 || busy !== 1'b1 || mosi !== f[23]) begin
        miscompares++; $display("FAIL single_start[%0d]: cs_n=%b busy=%b mosi=%b want 0/1/%b", i, cs_n, busy, mosi, f[23]);
      end
      wait_frames(1, 200);
      if (frame_q.size() > 0) begin
        vectors++; if (frame_q[0] !== f) begin miscompares++; $display("FAIL single_data[%0d]: got %h want %h", i, frame_q[0], f); end
        vectors++; if (fall_q[0] !== s + 1) begin miscompares++; $display("FAIL single_latency[%0d]: cs_n fell at %0d want %0d", i, fall_q[0], s + 1); end
        vectors++; if (len_q[0] !== 48 * D || bits_q[0] !== 24) begin
          miscompares++; $display("FAIL single_len[%0d]: low %0d bits %0d want %0d/24", i, len_q[0], bits_q[0], 48 * D);
        end
      end
      tick(H + 1);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle[%0d]: busy=%b want 0", i, busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    int s1, s2;
    a = 16'($urandom); b = 16'($urandom);
    clear_mon();
    strobe(a, s1);
    tick(3);
    strobe(b, s2);
    wait_frames(2, 400);
    if (frame_q.size() >= 2) begin
      vectors++; if (fall_q[1] - fall_q[0] !== 48 * D + H + 1) begin
        miscompares++; $display("FAIL b2b_period: got %0d want %0d", fall_q[1] - fall_q[0], 48 * D + H + 1);
      end
      vectors++; if (frame_q[0] !== exp_frame(a) || frame_q[1] !== exp_frame(b)) begin
        miscompares++; $display("FAIL b2b_data: got %h %h want %h %h", frame_q[0], frame_q[1], exp_frame(a), exp_frame(b));
      end
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tick(H + 2);
  endtask

  task automatic test_overrun();
    int s;
    clear_mon();
    strobe(16'h1111, s);
    tick(8);
    strobe(16'h2222, s);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_early: got %b want 0", overrun); end
    tick(8);
    strobe(16'h3333, s);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", overrun); end
    wait_frames(2, 400);
    tick(150);
    vectors++; if (frame_q.size() !== 2) begin miscompares++; $display("FAIL overrun_count: got %0d frames want 2", frame_q.size()); end
    if (frame_q.size() >= 2) begin
      vectors++; if (frame_q[0] !== exp_frame(16'h1111) || frame_q[1] !== exp_frame(16'h3333)) begin
        miscompares++; $display("FAIL overrun_data: got %h %h want %h %h", frame_q[0], frame_q[1], exp_frame(16'h1111), exp_frame(16'h3333));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] v;
    int s, k;
    clear_mon();
    strobe(16'($urandom), s);
    k = 0;
    while (nbits < 10 && k < 200) begin
      tick(1);
      k++;
    end
    vectors++; if (nbits < 10) begin miscompares++; $display("FAIL midreset_reach: got %0d rises want 10", nbits); end
    rst = 1'b1;
    #1;
    vectors++; if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_outputs: cs_n=%b sclk=%b mosi=%b busy=%b want 1/0/0/0", cs_n, sclk, mosi, busy);
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
    tick(2);
    rst = 1'b0;
    tick(2);
    clear_mon();
    v = 16'($urandom);
    strobe(v, s);
    wait_frames(1, 200);
    if (frame_q.size() > 0) begin
      vectors++; if (frame_q[0] !== exp_frame(v) || bits_q[0] !== 24 || fall_q[0] !== s + 1) begin
        miscompares++; $display("FAIL midreset_fresh: got %h bits %0d at %0d want %h 24 at %0d", frame_q[0], bits_q[0], fall_q[0], exp_frame(v), s + 1);
      end
    end
    tick(H + 2);
  endtask

  task automatic test_fast();
    int start_s;
    f_fall_q.delete(); f_len_q.delete(); f_viol = 0;
    @(posedge clk);
    #2;
    f_sample_en = 1'b1;
    start_s = cyc + 1;
    for (int i = 0; i < 160; i++) begin
      f_modulated = 16'($urandom);
      tick(1);
    end
    f_sample_en = 1'b0;
    tick(80);
    vectors++; if (f_fall_q.size() < 4) begin miscompares++; $display("FAIL fast_count: got %0d frames want >=4", f_fall_q.size()); end
    if (f_fall_q.size() >= 4) begin
      vectors++; if (f_fall_q[0] !== start_s + 1) begin miscompares++; $display("FAIL fast_latency: got %0d want %0d", f_fall_q[0], start_s + 1); end
      for (int i = 1; i < 4; i++) begin
        vectors++; if (f_fall_q[i] - f_fall_q[i-1] !== 48 * FD + FH + 1) begin
          miscompares++; $display("FAIL fast_period[%0d]: got %0d want %0d", i, f_fall_q[i] - f_fall_q[i-1], 48 * FD + FH + 1);
        end
      end
    end
    if (f_len_q.size() > 0) begin
      vectors++; if (f_len_q[0] !== 48 * FD) begin miscompares++; $display("FAIL fast_len: got %0d want %0d", f_len_q[0], 48 * FD); end
    end
    vectors++; if (f_viol !== 0) begin miscompares++; $display("FAIL fast_sclk_mosi: got %0d violations want 0", f_viol); end
    vectors++; if (f_overrun !== 1'b1) begin miscompares++; $display("FAIL fast_overrun: got %b want 1", f_overrun); end
  endtask

  task automatic test_random();
    int          st[$];
    logic [15:0] sv[$];
    int          ef[$];
    logic [23:0] ev[$];
    int          idle_t, pt, e, s, n;
    bit          pv, ov;
    logic [15:0] pval, v;
    pulse_reset();
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      tick($urandom_range(0, 120));
      v = 16'($urandom);
      strobe(v, s);
      st.push_back(s);
      sv.push_back(v);
    end
    // Frame-level model: a pending sample launches one edge after both it and the idle slot exist
    idle_t = -100000; pv = 1'b0; ov = 1'b0; pt = 0; pval = '0;
    for (int i = 0; i < st.size(); i++) begin
      if (pv) begin
        e = ((pt > idle_t) ? pt : idle_t) + 1;
        if (e <= st[i]) begin
          ef.push_back(e); ev.push_back(exp_frame(pval));
          idle_t = e + 48 * D + H;
          pv = 1'b0;
        end
      end
      if (pv) ov = 1'b1;
      pv = 1'b1; pt = st[i]; pval = sv[i];
    end
    if (pv) begin
      e = ((pt > idle_t) ? pt : idle_t) + 1;
      ef.push_back(e); ev.push_back(exp_frame(pval));
    end
    wait_frames(ef.size(), 400);
    tick(110);
    vectors++; if (frame_q.size() !== ef.size()) begin miscompares++; $display("FAIL rand_count: got %0d frames want %0d", frame_q.size(), ef.size()); end
    n = (frame_q.size() < ef.size()) ? frame_q.size() : ef.size();
    for (int i = 0; i < n; i++) begin
      vectors++; if (frame_q[i] !== ev[i] || fall_q[i] !== ef[i]) begin
        miscompares++; $display("FAIL rand_frame[%0d]: got %h at %0d want %h at %0d", i, frame_q[i], fall_q[i], ev[i], ef[i]);
      end
    end
    vectors++; if (overrun !== ov) begin miscompares++; $display("FAIL rand_overrun: got %b want %b", overrun, ov); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_fast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
